// File: rtl/acc_mon_pkg.sv
// Shared types and constants for the accuracy monitor.
package acc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } acc_state_e;

    localparam int PCT_SCALE = 100;
    localparam int PCT_W     = 7;

endpackage

// File: rtl/acc_divider.sv
// Iterative restoring divider: i_start latches operands, one quotient bit per cycle,
// o_done pulses for one cycle once all W bits are produced.
module acc_divider #(
    parameter int W     = 27,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [W-1:0]     i_num,
    input  logic [W-1:0]     i_den,
    output logic             o_done,
    output logic [OUT_W-1:0] o_quo
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_den;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_qbit;

    // Remainder stays below the divisor, so W+1 bits hold the shifted trial value.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, r_den};
    assign w_qbit  = ~w_diff[W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_rem  <= '0;
                r_quo  <= i_num;
                r_den  <= i_den;
                r_cnt  <= CW'(W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], w_qbit};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quo  = r_quo[OUT_W-1:0];

endmodule

// File: rtl/accuracy_monitor.sv
// Counts classifier hits against a label memory and reports floor(100*correct/total).
// Optional per-class statistics are built when ACC_MON_PER_CLASS_EN is defined.
module accuracy_monitor
    import acc_mon_pkg::*;
#(
    parameter int LBL_W  = 8,
    parameter int DEPTH  = 750,
    parameter int NCLASS = 10,
    parameter int CNT_W  = 20
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         res_valid,
    input  logic [LBL_W-1:0]                             result,
    input  logic                                         finish,
    input  logic                                         lbl_we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] lbl_addr,
    input  logic [LBL_W-1:0]                             lbl_wdata,
`ifdef ACC_MON_PER_CLASS_EN
    input  logic [((NCLASS > 1) ? $clog2(NCLASS) : 1)-1:0] class_sel,
    output logic [CNT_W-1:0]                             class_total,
    output logic [CNT_W-1:0]                             class_hits,
`endif
    output logic [CNT_W-1:0]                             total,
    output logic [CNT_W-1:0]                             correct,
    output logic [PCT_W-1:0]                             acc_pct,
    output logic                                         acc_valid,
    output logic                                         div_zero,
    output logic                                         overflow,
    output logic                                         busy
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIV_W = CNT_W + PCT_W;

    acc_state_e       r_state;
    logic [LBL_W-1:0] r_lbl_mem [DEPTH];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_correct;
    logic [PCT_W-1:0] r_acc_pct;
    logic             r_div_zero;
    logic             r_overflow;

    logic             w_rest;
    logic             w_run;
    logic             w_go;
    logic             w_full;
    logic [LBL_W-1:0] w_label;
    logic             w_accept;
    logic             w_hit;
    logic [CNT_W-1:0] w_total_nxt;
    logic [CNT_W-1:0] w_correct_nxt;
    logic             w_fin;
    logic             w_div_start;
    logic [DIV_W-1:0] w_num;
    logic [DIV_W-1:0] w_den;
    logic             w_div_done;
    logic [PCT_W-1:0] w_quo;

    assign w_rest   = (r_state == IDLE) || (r_state == DONE);
    assign w_run    = (r_state == RUN);
    assign w_go     = start && w_rest;
    assign w_full   = (r_total == CNT_W'(DEPTH));
    assign w_label  = r_lbl_mem[r_total[AW-1:0]];
    assign w_accept = w_run && res_valid && !w_full;
    assign w_hit    = w_accept && (w_label == result);

    // Divider operands come from the post-update counts so a sample arriving
    // with finish is included in the result.
    assign w_total_nxt   = r_total + CNT_W'(w_accept);
    assign w_correct_nxt = r_correct + CNT_W'(w_hit);
    assign w_fin         = w_run && finish;
    assign w_div_start   = w_fin && (w_total_nxt != '0);
    assign w_num         = DIV_W'(w_correct_nxt) * DIV_W'(PCT_SCALE);
    assign w_den         = DIV_W'(w_total_nxt);

    acc_divider #(
        .W     (DIV_W),
        .OUT_W (PCT_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_num   (w_num),
        .i_den   (w_den),
        .o_done  (w_div_done),
        .o_quo   (w_quo)
    );

    // Label memory holds contents across rst and start.
    always_ff @(posedge clk) begin
        if (lbl_we && w_rest && ({1'b0, lbl_addr} < (AW + 1)'(DEPTH)))
            r_lbl_mem[lbl_addr] <= lbl_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_total    <= '0;
            r_correct  <= '0;
            r_acc_pct  <= '0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_total    <= '0;
                        r_correct  <= '0;
                        r_acc_pct  <= '0;
                        r_div_zero <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    r_total   <= w_total_nxt;
                    r_correct <= w_correct_nxt;
                    if (res_valid && w_full)
                        r_overflow <= 1'b1;
                    if (finish) begin
                        if (w_total_nxt == '0) begin
                            r_state    <= DONE;
                            r_acc_pct  <= '0;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state   <= DONE;
                        r_acc_pct <= w_quo;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign total     = r_total;
    assign correct   = r_correct;
    assign acc_pct   = r_acc_pct;
    assign acc_valid = (r_state == DONE);
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;
    assign busy      = (r_state == RUN) || (r_state == DIV);

`ifdef ACC_MON_PER_CLASS_EN
    logic [CNT_W-1:0] r_cls_tot [NCLASS];
    logic [CNT_W-1:0] r_cls_hit [NCLASS];
    logic [CNT_W-1:0] r_class_total;
    logic [CNT_W-1:0] r_class_hits;

    // Labels outside 0..NCLASS-1 match no counter and only reach total.
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            for (int c = 0; c < NCLASS; c++) begin
                r_cls_tot[c] <= '0;
                r_cls_hit[c] <= '0;
            end
        end else if (w_accept) begin
            for (int c = 0; c < NCLASS; c++) begin
                if (w_label == LBL_W'(c)) begin
                    r_cls_tot[c] <= r_cls_tot[c] + CNT_W'(1);
                    if (w_hit)
                        r_cls_hit[c] <= r_cls_hit[c] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_class_total <= '0;
            r_class_hits  <= '0;
        end else if (int'(class_sel) < NCLASS) begin
            r_class_total <= r_cls_tot[class_sel];
            r_class_hits  <= r_cls_hit[class_sel];
        end else begin
            r_class_total <= '0;
            r_class_hits  <= '0;
        end
    end

    assign class_total = r_class_total;
    assign class_hits  = r_class_hits;
`endif

endmodule

// File: tb/tb_accuracy_monitor.sv
// Randomized self-checking bench for accuracy_monitor against a sample-list reference model.
module tb_accuracy_monitor;
    localparam int LBL_W  = 8;
    localparam int DEPTH  = 750;
    localparam int NCLASS = 10;
    localparam int CNT_W  = 20;
    localparam int AW     = 10;

    logic              clk = 1'b0;
    logic              rst, start, res_valid, finish, lbl_we;
    logic [LBL_W-1:0]  result, lbl_wdata;
    logic [AW-1:0]     lbl_addr;
    logic [CNT_W-1:0]  total, correct;
    logic [6:0]        acc_pct;
    logic              acc_valid, div_zero, overflow, busy;
`ifdef ACC_MON_PER_CLASS_EN
    logic [3:0]        class_sel;
    logic [CNT_W-1:0]  class_total, class_hits;
`endif

    accuracy_monitor #(
        .LBL_W(LBL_W), .DEPTH(DEPTH), .NCLASS(NCLASS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .result(result),
        .finish(finish), .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_wdata(lbl_wdata),
`ifdef ACC_MON_PER_CLASS_EN
        .class_sel(class_sel), .class_total(class_total), .class_hits(class_hits),
`endif
        .total(total), .correct(correct), .acc_pct(acc_pct), .acc_valid(acc_valid),
        .div_zero(div_zero), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: label list plus plain counts of the accepted samples.
    int m_lbl [DEPTH];
    int m_tot, m_cor;
    bit m_ov;
    int m_ctot [NCLASS];
    int m_chit [NCLASS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lbl(input int a, input int v);
        lbl_we = 1'b1; lbl_addr = AW'(a); lbl_wdata = LBL_W'(v);
        tick();
        lbl_we = 1'b0;
        m_lbl[a] = v;
    endtask

    task automatic model_sample(input int r);
        if (m_tot >= DEPTH) begin
            m_ov = 1'b1;
        end else begin
            if (m_lbl[m_tot] < NCLASS) begin
                m_ctot[m_lbl[m_tot]]++;
                if (r == m_lbl[m_tot]) m_chit[m_lbl[m_tot]]++;
            end
            if (r == m_lbl[m_tot]) m_cor++;
            m_tot++;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".total"}, total, 0);
        chk({nm, ".correct"}, correct, 0);
        chk({nm, ".pct"}, acc_pct, 0);
        chk({nm, ".acc_valid"}, acc_valid, 0);
        chk({nm, ".div_zero"}, div_zero, 0);
        chk({nm, ".overflow"}, overflow, 0);
        chk({nm, ".busy"}, busy, 0);
    endtask

    // mode 0: all match, 1: random with gaps and ignored stimulus, 2: pattern bits.
    task automatic do_run(input int n, input int mode, input logic [7:0] pat,
                          input bit fin_last, input int rst_at, input string nm);
        int lb, r, lat, exp_pct;
        bit m;
        start = 1'b1; tick(); start = 1'b0;
        m_tot = 0; m_cor = 0; m_ov = 1'b0;
        for (int c = 0; c < NCLASS; c++) begin m_ctot[c] = 0; m_chit[c] = 0; end
        chk({nm, ".busy_run"}, busy, 1);
        chk({nm, ".total_clr"}, total, 0);
        chk({nm, ".valid_clr"}, acc_valid, 0);
        for (int i = 0; i < n; i++) begin
            if (mode == 1) begin
                while ($urandom_range(3) == 0) begin
                    start = 1'(($urandom_range(1)));
                    lbl_we = 1'b1; lbl_addr = AW'(m_tot % DEPTH);
                    lbl_wdata = LBL_W'($urandom_range(255));
                    tick();
                    start = 1'b0; lbl_we = 1'b0;
                end
            end
            lb = (m_tot < DEPTH) ? m_lbl[m_tot] : 0;
            m = (mode == 0) ? 1'b1 : (mode == 2) ? pat[i] : 1'($urandom_range(1));
            r = m ? lb : ((lb ^ int'($urandom_range(1, 255))) & 255);
            res_valid = 1'b1; result = LBL_W'(r);
            model_sample(r);
            if (fin_last && i == n - 1) finish = 1'b1;
            tick();
            res_valid = 1'b0; finish = 1'b0;
        end
        if (!fin_last || n == 0) begin
            finish = 1'b1; tick(); finish = 1'b0;
        end
        chk({nm, ".total"}, total, m_tot);
        chk({nm, ".correct"}, correct, m_cor);
        chk({nm, ".overflow"}, overflow, m_ov);
        if (rst_at > 0) begin
            repeat (rst_at) tick();
            chk({nm, ".busy_div"}, busy, 1);
            rst = 1'b1; tick(); rst = 1'b0;
            check_zero({nm, ".rst"});
            tick();
            chk({nm, ".rst_idle"}, busy, 0);
            return;
        end
        lat = 0;
        while (!acc_valid && lat < 200) begin
            if (lat == 3) begin start = 1'b1; res_valid = 1'b1; result = '0; end
            tick();
            start = 1'b0; res_valid = 1'b0;
            lat++;
        end
        exp_pct = (m_tot == 0) ? 0 : (100 * m_cor) / m_tot;
        chk({nm, ".latency"}, lat, (m_tot == 0) ? 0 : CNT_W + 8);
        chk({nm, ".pct"}, acc_pct, exp_pct);
        chk({nm, ".div_zero"}, div_zero, (m_tot == 0));
        chk({nm, ".busy_done"}, busy, 0);
        res_valid = 1'b1; finish = 1'b1; result = '0; tick();
        res_valid = 1'b0; finish = 1'b0; tick();
        chk({nm, ".hold_valid"}, acc_valid, 1);
        chk({nm, ".hold_total"}, total, m_tot);
        chk({nm, ".hold_pct"}, acc_pct, exp_pct);
`ifdef ACC_MON_PER_CLASS_EN
        class_sel = 4'd3; tick();
        chk({nm, ".cls3_tot"}, class_total, m_ctot[3]);
        chk({nm, ".cls3_hit"}, class_hits, m_chit[3]);
        lb = $urandom_range(NCLASS - 1);
        class_sel = 4'(lb); tick();
        chk({nm, ".clsr_tot"}, class_total, m_ctot[lb]);
        chk({nm, ".clsr_hit"}, class_hits, m_chit[lb]);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_valid = 1'b0; finish = 1'b0; lbl_we = 1'b0;
        result = '0; lbl_wdata = '0; lbl_addr = '0;
`ifdef ACC_MON_PER_CLASS_EN
        class_sel = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        check_zero("reset");

        res_valid = 1'b1; finish = 1'b1; tick(); res_valid = 1'b0; finish = 1'b0; tick();
        check_zero("idle_ignore");

        for (int i = 0; i < DEPTH; i++) wr_lbl(i, i % 10);

        do_run(750, 0, 8'h00, 1'b0, 0, "full");
        do_run(4,   2, 8'b0111, 1'b0, 0, "pct75");
        do_run(3,   2, 8'b0011, 1'b0, 0, "pct66");
        do_run(0,   0, 8'h00, 1'b0, 0, "empty");
        do_run(1,   0, 8'h00, 1'b1, 0, "same_cycle");

`ifdef ACC_MON_PER_CLASS_EN
        for (int i = 0; i < 5; i++) wr_lbl(i, 3);
        do_run(5, 2, 8'b00101, 1'b0, 0, "class3");
        for (int i = 0; i < 5; i++) wr_lbl(i, i % 10);
`endif

        for (int i = 0; i < 60; i++) wr_lbl($urandom_range(DEPTH - 1), $urandom_range(15));
        for (int k = 0; k < 4; k++)
            do_run($urandom_range(1, 150), 1, 8'h00, 1'($urandom_range(1)), 0, "rnd");

        do_run(751, 0, 8'h00, 1'b0, 5, "ovf");
        do_run(40, 1, 8'h00, 1'b0, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no summary expected finish");
        $fatal(1);
    end
endmodule

// File: doc/accuracy_monitor.md
ACCURACY_MONITOR -- requirements
Module: accuracy_monitor

Interface
REQ-001 Parameter LBL_W, default 8, width of result and label values.
REQ-002 Parameter DEPTH, default 750, label memory entries (maximum samples per run).
REQ-003 Parameter NCLASS, default 10, number of classes for per-class statistics.
REQ-004 Parameter CNT_W, default 20, sample/hit counter width; CNT_W SHALL satisfy 2^CNT_W > DEPTH.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse: clear statistics, begin run.
REQ-008 res_valid  in  1  one sample per high cycle (network batch-done strobe).
REQ-009 result  in  LBL_W  predicted class, sampled when res_valid=1.
REQ-010 finish  in  1  single-cycle pulse: end of run, request accuracy.
REQ-011 lbl_we / lbl_addr / lbl_wdata  in  1 / clog2(DEPTH) / LBL_W  label memory write port.
REQ-012 total, correct  out  CNT_W each  live sample and hit counts.
REQ-013 acc_pct  out  7  accuracy = floor(100*correct/total), 0..100.
REQ-014 acc_valid  out  1  high (level) while acc_pct is valid, in DONE only.
REQ-015 div_zero, overflow, busy  out  1 each  total=0 at finish; sample dropped because total=DEPTH; state is RUN or DIV.

Function
REQ-016 States IDLE, RUN, DIV, DONE; reset enters IDLE.
REQ-017 IDLE/DONE + start -> RUN next cycle; total, correct, overflow, div_zero, acc_valid, acc_pct cleared that same edge.
REQ-018 start SHALL be ignored in RUN and DIV.
REQ-019 RUN + res_valid: compare result with label_mem[total]; total+1, correct+1 on match, both registered on that edge.
REQ-020 RUN + res_valid with total=DEPTH: sample dropped, counters hold, overflow sets sticky until next start.
REQ-021 RUN + finish -> DIV; res_valid in the same cycle SHALL be counted before the divide operands are latched.
REQ-022 DIV: restoring divider, numerator correct*100 (CNT_W+7 bits), divisor total, one quotient bit per cycle, exactly CNT_W+7 cycles.
REQ-023 DONE entered exactly CNT_W+8 cycles after the finish edge; acc_valid=1 and acc_pct held until next start or rst.
REQ-024 total=0 at finish: DIV skipped, DONE next cycle, acc_pct=0, div_zero=1.
REQ-025 res_valid and finish outside RUN SHALL be ignored.
REQ-026 Label writes accepted in IDLE/DONE only; ignored in RUN/DIV; memory contents not cleared by rst or start.
REQ-027 Label reads combinational or registered internally; sample comparison SHALL still complete in the res_valid cycle's edge.

Reset
REQ-028 rst SHALL override every input, including mid-RUN or mid-DIV.
REQ-029 Reset values: state IDLE, total=0, correct=0, acc_pct=0, acc_valid=0, div_zero=0, overflow=0, busy=0, per-class counters 0.

Configuration
REQ-030 Macro ACC_MON_PER_CLASS_EN defined: add inputs class_sel (clog2(NCLASS)) and outputs class_total, class_hits (CNT_W each), registered one cycle after class_sel; per-class counters indexed by label, updated with REQ-019, cleared with REQ-017; labels >= NCLASS count in total only.
REQ-031 Macro undefined: no per-class ports, counters or logic; remaining behaviour identical.

Structure
REQ-032 Package acc_mon_pkg holds state enum (IDLE, RUN, DIV, DONE) and constant PCT_SCALE=100.
REQ-033 Sub-module acc_divider: start/done handshake iterative restoring divider, parametrised by width.

Verification
REQ-034 Labels 0..9 repeating, 750 res_valid with result=label, finish -> total=750, correct=750, acc_pct=100 at finish+CNT_W+8.
REQ-035 4 samples, 3 matching, finish -> acc_pct=75; 3 samples, 2 matching -> acc_pct=66 (floor).
REQ-036 start then finish with no samples -> DONE next cycle, div_zero=1, acc_pct=0.
REQ-037 res_valid and finish same cycle after 1 matching sample -> total=1, correct=1, acc_pct=100.
REQ-038 751 res_valid with DEPTH=750 -> total=750, overflow=1; then rst mid-DIV -> IDLE, all outputs 0 next cycle.
REQ-039 ACC_MON_PER_CLASS_EN: 5 samples label 3, 2 matching, class_sel=3 -> class_total=5, class_hits=2 one cycle later.
